// File: rtl/spi_responder.sv
// SPI target endpoint: oversamples SCLK/CS_n/MOSI in clk, shifts one MSB-first frame per transfer.
// Latency: pin edge to rx_valid within 4 clk cycles (2-flop sync + edge flop + output register).
// Backpressure: one-entry tx holding buffer (tx_ready low while full); rx side is a non-stallable pulse.
module spi_responder #(
    parameter int              WIDTH      = 8,
    parameter bit              CPOL       = 1'b0,
    parameter bit              CPHA       = 1'b1,
    parameter logic [WIDTH-1:0] DEFAULT_TX = 8'hFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             spi_sclk,
    input  logic             spi_cs_n,
    input  logic             spi_mosi,
    output logic             spi_miso,
    output logic             spi_miso_oe,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx_underrun,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy
);

    localparam int                CNT_W     = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(WIDTH - 1);
    localparam logic [0:0]        ST_IDLE   = 1'b0;
    localparam logic [0:0]        ST_ACTIVE = 1'b1;

    // Bit [1] is the synchronized level, bit [2] the previous one for edge detection.
    logic [2:0]       sclk_sync_q, cs_sync_q, mosi_sync_q;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic             buf_full_q, buf_full_d;
    logic             miso_q, miso_d;
    logic             rx_valid_q, rx_valid_d;
    logic             underrun_q, underrun_d;

    logic             sclk_s, sclk_p, cs_s, cs_p, mosi_s;
    logic             lead_edge, trail_edge, sample_edge, shift_edge;
    logic             cs_fall, cs_rise;
    logic             frame_start;
    logic [WIDTH-1:0] load_frame;

    assign sclk_s = sclk_sync_q[1];
    assign sclk_p = sclk_sync_q[2];
    assign cs_s   = cs_sync_q[1];
    assign cs_p   = cs_sync_q[2];
    assign mosi_s = mosi_sync_q[1];

    // SCLK edges only count while the target is selected.
    assign lead_edge   = !cs_s && (sclk_s != CPOL) && (sclk_p == CPOL);
    assign trail_edge  = !cs_s && (sclk_s == CPOL) && (sclk_p != CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge  : trail_edge;
    assign cs_fall     = (state_q == ST_IDLE)   && cs_p && !cs_s;
    assign cs_rise     = (state_q == ST_ACTIVE) && cs_s;

    assign load_frame  = buf_full_q ? buf_q : DEFAULT_TX;

    // Synchronize the asynchronous pins and keep one extra stage for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= {3{CPOL}};
            cs_sync_q   <= 3'b111;
            mosi_sync_q <= 3'b000;
        end else begin
            sclk_sync_q <= {sclk_sync_q[1:0], spi_sclk};
            cs_sync_q   <= {cs_sync_q[1:0], spi_cs_n};
            mosi_sync_q <= {mosi_sync_q[1:0], spi_mosi};
        end
    end

    // Frame sequencing, shifting, sampling and holding-buffer bookkeeping.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        buf_d       = buf_q;
        buf_full_d  = buf_full_q;
        miso_d      = miso_q;
        rx_valid_d  = 1'b0;
        frame_start = 1'b0;

        if (cs_fall) begin
            state_d     = ST_ACTIVE;
            frame_start = 1'b1;
            cnt_d       = '0;
            rx_shift_d  = '0;
            if (!CPHA) begin
                // CPHA=0 presents the MSB before the first leading edge.
                miso_d     = load_frame[WIDTH-1];
                tx_shift_d = load_frame << 1;
            end else begin
                tx_shift_d = load_frame;
            end
        end else if (cs_rise) begin
            // Deselect: any partial frame in either direction is dropped.
            state_d    = ST_IDLE;
            cnt_d      = '0;
            rx_shift_d = '0;
            tx_shift_d = '0;
            miso_d     = 1'b0;
        end else if (state_q == ST_ACTIVE) begin
            if (shift_edge) begin
                miso_d     = tx_shift_q[WIDTH-1];
                tx_shift_d = tx_shift_q << 1;
            end
            if (sample_edge) begin
                rx_shift_d = {rx_shift_q[WIDTH-2:0], mosi_s};
                if (cnt_q == LAST_BIT) begin
                    // Last bit: publish the frame and start the next one without idle SCLK.
                    cnt_d       = '0;
                    rx_data_d   = rx_shift_d;
                    rx_valid_d  = 1'b1;
                    frame_start = 1'b1;
                    tx_shift_d  = load_frame;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        underrun_d = frame_start && !buf_full_q;
        if (frame_start && buf_full_q) begin
            buf_full_d = 1'b0;
        end
        // Accepted only while empty, so a write in a frame-start cycle waits for the next frame.
        if (tx_valid && !buf_full_q) begin
            buf_d      = tx_data;
            buf_full_d = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            miso_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            miso_q     <= miso_d;
            rx_valid_q <= rx_valid_d;
            underrun_q <= underrun_d;
        end
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = (state_q == ST_ACTIVE);
    assign tx_ready    = !buf_full_q;
    assign tx_underrun = underrun_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign busy        = (state_q == ST_ACTIVE) && (cnt_q != '0);

endmodule

// File: tb/tb_spi_responder.sv
// Bench for spi_responder: two instances (CPOL0/CPHA1 and CPOL1/CPHA0) share one initiator.
// The initiator holds MOSI across both edges of a bit so both phase modes sample the same data.
// Directed frames with hand-computed expected MISO/RX values.
module tb_spi_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk, sclk_b, cs_n, mosi;
    logic [7:0] tx_data;
    logic       tx_valid;

    logic       miso_a, oe_a, tx_ready_a, und_a, rxv_a, busy_a;
    logic       miso_b, oe_b, tx_ready_b, und_b, rxv_b, busy_b;
    logic [7:0] rx_a, rx_b;

    int n_checks = 0;
    int n_fail   = 0;
    int rxv_cnt_a = 0, rxv_cnt_b = 0, und_cnt_a = 0, und_cnt_b = 0;
    int base_ra, base_rb, base_ua, base_ub;
    logic [7:0] ma, mb;

    always #5 clk = ~clk;

    // Instance B idles high; it sees the same logical leading/trailing edges as A.
    assign sclk_b = ~sclk;

    spi_responder #(.WIDTH(8), .CPOL(1'b0), .CPHA(1'b1), .DEFAULT_TX(8'hFF)) dut_a (
        .clk(clk), .rst(rst), .spi_sclk(sclk), .spi_cs_n(cs_n), .spi_mosi(mosi),
        .spi_miso(miso_a), .spi_miso_oe(oe_a), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready_a), .tx_underrun(und_a), .rx_data(rx_a), .rx_valid(rxv_a),
        .busy(busy_a)
    );

    spi_responder #(.WIDTH(8), .CPOL(1'b1), .CPHA(1'b0), .DEFAULT_TX(8'hFF)) dut_b (
        .clk(clk), .rst(rst), .spi_sclk(sclk_b), .spi_cs_n(cs_n), .spi_mosi(mosi),
        .spi_miso(miso_b), .spi_miso_oe(oe_b), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready_b), .tx_underrun(und_b), .rx_data(rx_b), .rx_valid(rxv_b),
        .busy(busy_b)
    );

    // Pulse counters; tests compare deltas so these are never cleared.
    always @(negedge clk) begin
        if (rxv_a) rxv_cnt_a++;
        if (rxv_b) rxv_cnt_b++;
        if (und_a) und_cnt_a++;
        if (und_b) und_cnt_b++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_miso_a"},  miso_a, 0);     check({tag, "_miso_b"},  miso_b, 0);
        check({tag, "_oe_a"},    oe_a, 0);       check({tag, "_oe_b"},    oe_b, 0);
        check({tag, "_rdy_a"},   tx_ready_a, 1); check({tag, "_rdy_b"},   tx_ready_b, 1);
        check({tag, "_und_a"},   und_a, 0);      check({tag, "_rx_a"},    rx_a, 0);
        check({tag, "_rxv_a"},   rxv_a, 0);      check({tag, "_busy_a"},  busy_a, 0);
        check({tag, "_rx_b"},    rx_b, 0);       check({tag, "_busy_b"},  busy_b, 0);
    endtask

    task automatic push_tx(input logic [7:0] d);
        int k = 0;
        while (!tx_ready_a && k < 200) begin
            wait_clks(1);
            k++;
        end
        check("push_ready", tx_ready_a, 1);
        tx_data  = d;
        tx_valid = 1'b1;
        wait_clks(1);
        tx_valid = 1'b0;
    endtask

    // Shift nbits of d MSB-first; capture B's MISO before each leading edge, A's before each trailing edge.
    task automatic spi_bits(input logic [7:0] d, input int nbits,
                            output logic [7:0] got_a, output logic [7:0] got_b);
        got_a = '0;
        got_b = '0;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = d[i];
            wait_clks(4);
            got_b = {got_b[6:0], miso_b};
            sclk  = 1'b1;
            wait_clks(8);
            got_a = {got_a[6:0], miso_a};
            sclk  = 1'b0;
            wait_clks(4);
        end
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        wait_clks(8);
    endtask

    task automatic cs_high();
        cs_n = 1'b1;
        wait_clks(8);
    endtask

    initial begin
        rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; tx_data = '0; tx_valid = 1'b0;
        wait_clks(3);
        check_reset_vals("reset");
        rst = 1'b0;
        wait_clks(4);

        // Preloaded A5 out, 3C in.
        push_tx(8'hA5);
        check("t1_ready_low", tx_ready_a, 0);
        base_ua = und_cnt_a; base_ub = und_cnt_b;
        base_ra = rxv_cnt_a; base_rb = rxv_cnt_b;
        cs_low();
        check("t1_oe", oe_a, 1);
        check("t1_ready_back", tx_ready_a, 1);
        check("t1_no_underrun", und_cnt_a - base_ua, 0);
        spi_bits(8'h3C, 8, ma, mb);
        check("t1_miso_a", ma, 8'hA5);
        check("t1_miso_b", mb, 8'hA5);
        check("t1_rx_a", rx_a, 8'h3C);
        check("t1_rx_b", rx_b, 8'h3C);
        check("t1_rxv_a", rxv_cnt_a - base_ra, 1);
        check("t1_rxv_b", rxv_cnt_b - base_rb, 1);
        cs_high();
        check("t1_oe_off", oe_a, 0);
        check("t1_busy", busy_a, 0);

        // C3 out, 81 in; CPHA=0 instance presents MSB before the first leading edge.
        push_tx(8'hC3);
        cs_low();
        check("t2_miso_b_pre", miso_b, 1);
        spi_bits(8'h81, 8, ma, mb);
        check("t2_miso_b", mb, 8'hC3);
        check("t2_miso_a", ma, 8'hC3);
        check("t2_rx_b", rx_b, 8'h81);
        check("t2_rx_a", rx_a, 8'h81);
        cs_high();

        // Empty buffer at select: default frame and one underrun at the start.
        base_ua = und_cnt_a; base_ub = und_cnt_b; base_ra = rxv_cnt_a;
        cs_low();
        check("t3_und_a", und_cnt_a - base_ua, 1);
        check("t3_und_b", und_cnt_b - base_ub, 1);
        spi_bits(8'h6E, 8, ma, mb);
        check("t3_miso_a", ma, 8'hFF);
        check("t3_miso_b", mb, 8'hFF);
        check("t3_rx_a", rx_a, 8'h6E);
        check("t3_rxv_a", rxv_cnt_a - base_ra, 1);
        cs_high();

        // Back-to-back frames, second tx word written during the first frame.
        push_tx(8'h11);
        base_ra = rxv_cnt_a; base_rb = rxv_cnt_b;
        cs_low();
        fork
            spi_bits(8'h5A, 8, ma, mb);
            begin
                wait_clks(40);
                push_tx(8'h22);
            end
        join
        check("t4_miso_a1", ma, 8'h11);
        check("t4_miso_b1", mb, 8'h11);
        check("t4_rx_a1", rx_a, 8'h5A);
        spi_bits(8'hC6, 8, ma, mb);
        check("t4_miso_a2", ma, 8'h22);
        check("t4_miso_b2", mb, 8'h22);
        check("t4_rx_a2", rx_a, 8'hC6);
        check("t4_rx_b2", rx_b, 8'hC6);
        check("t4_rxv_a", rxv_cnt_a - base_ra, 2);
        check("t4_rxv_b", rxv_cnt_b - base_rb, 2);
        cs_high();

        // Deselect after five bits, then a clean frame.
        base_ra = rxv_cnt_a; base_rb = rxv_cnt_b;
        cs_low();
        spi_bits(8'hF0, 5, ma, mb);
        check("t5_busy_mid_a", busy_a, 1);
        check("t5_busy_mid_b", busy_b, 1);
        cs_high();
        check("t5_no_rxv_a", rxv_cnt_a - base_ra, 0);
        check("t5_no_rxv_b", rxv_cnt_b - base_rb, 0);
        check("t5_rx_hold_a", rx_a, 8'hC6);
        check("t5_rx_hold_b", rx_b, 8'hC6);
        check("t5_busy_a", busy_a, 0);
        check("t5_busy_b", busy_b, 0);
        cs_low();
        spi_bits(8'h96, 8, ma, mb);
        check("t5_rx_a", rx_a, 8'h96);
        check("t5_rx_b", rx_b, 8'h96);
        check("t5_rxv_a", rxv_cnt_a - base_ra, 1);
        cs_high();

        // Reset mid-frame with a frame waiting in the buffer.
        push_tx(8'h77);
        cs_low();
        spi_bits(8'hAA, 3, ma, mb);
        push_tx(8'h78);
        check("t6_buf_full", tx_ready_a, 0);
        check("t6_busy", busy_a, 1);
        rst = 1'b1;
        wait_clks(1);
        check_reset_vals("t6");
        cs_n = 1'b1;
        wait_clks(3);
        rst = 1'b0;
        wait_clks(8);
        check("t6_ready_after", tx_ready_a, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
